// File: rtl/quant_scheduler.sv
// Issue scheduler for one shared 8x8 quantizer fed by the Y, Cb and Cr block producers.
// Arbitrates requests, tags in-flight blocks and meters downstream buffer credits.
//
// state | meaning
// S_Y   | issuing the Y blocks of the current MCU (ycnt counts them)
// S_CB  | waiting to issue the Cb block
// S_CR  | waiting to issue the Cr block that closes the MCU
module quant_scheduler #(
    parameter int STRICT_MCU = 1,
    parameter int Y_PER_MCU  = 4,
    parameter int Q_LAT      = 4,
    parameter int CREDITS    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   req,
    output logic [2:0]                   gnt,
    output logic [1:0]                   q_sel,
    output logic                         q_enable,
    input  logic                         q_out_enable,
    output logic                         out_valid,
    output logic [1:0]                   out_comp,
    output logic                         out_mcu_last,
    input  logic                         credit_return,
    output logic [$clog2(CREDITS+1)-1:0] credits_avail,
    output logic                         busy,
    output logic                         err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int AW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [AW-1:0] PTR_LAST  = AW'(CREDITS - 1);
    localparam logic [1:0]    YCNT_LAST = 2'(Y_PER_MCU - 1);

    // The tag FIFO must hold every block that can be in the quantizer at once.
    if (CREDITS < Q_LAT || Y_PER_MCU < 1 || Y_PER_MCU > 4) begin : g_param_check
        $error("quant_scheduler: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        S_Y  = 2'd0,
        S_CB = 2'd1,
        S_CR = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    ycnt, ycnt_nxt;
    logic [1:0]    rr_ptr, rr_ptr_nxt;
    logic [1:0]    cand;
    logic          cand_vld;
    logic          issue;
    logic          tag_last;
    logic [2:0]    gnt_nxt;

    logic [2:0]    tag_mem [CREDITS];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, bypass, ret_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_Y;
            ycnt   <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            ycnt   <= ycnt_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        logic [1:0] idx;
        cand     = 2'd0;
        cand_vld = 1'b0;
        idx      = rr_ptr;
        if (STRICT_MCU != 0) begin
            cand     = state;
            cand_vld = req[cand];
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!cand_vld && req[idx]) begin
                    cand     = idx;
                    cand_vld = 1'b1;
                end
                idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
        issue = cand_vld && (credits_avail != '0);

        state_nxt  = state;
        ycnt_nxt   = ycnt;
        rr_ptr_nxt = rr_ptr;
        if (issue) begin
            if (STRICT_MCU != 0) begin
                unique case (state)
                    S_Y: begin
                        if (ycnt == YCNT_LAST) begin
                            ycnt_nxt  = '0;
                            state_nxt = S_CB;
                        end else begin
                            ycnt_nxt = ycnt + 2'd1;
                        end
                    end
                    S_CB:    state_nxt = S_CR;
                    S_CR:    state_nxt = S_Y;
                    default: state_nxt = S_Y;
                endcase
            end else begin
                rr_ptr_nxt = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            end
        end
    end

    always_comb begin
        gnt_nxt  = 3'b000;
        tag_last = 1'b0;
        if (issue) begin
            gnt_nxt  = 3'b001 << cand;
            tag_last = (STRICT_MCU != 0) && (cand == 2'd2);
        end
    end

    // An empty FIFO with a same-cycle push hands the new tag straight to the output.
    assign pop    = q_out_enable && ((count != '0) || issue);
    assign bypass = pop && issue && (count == '0);
    assign ret_ok = credit_return && (credits_avail != CRED_MAX);
    assign busy   = (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt           <= '0;
            q_sel         <= '0;
            q_enable      <= 1'b0;
            credits_avail <= CRED_MAX;
            out_valid     <= 1'b0;
            out_comp      <= '0;
            out_mcu_last  <= 1'b0;
            err           <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            gnt      <= gnt_nxt;
            q_enable <= issue;
            if (issue) q_sel <= cand;

            if (issue && !ret_ok)      credits_avail <= credits_avail - CW'(1);
            else if (ret_ok && !issue) credits_avail <= credits_avail + CW'(1);

            if (issue && !bypass) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            if (pop && !bypass)   rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            if (issue && !pop)      count <= count + CW'(1);
            else if (pop && !issue) count <= count - CW'(1);

            out_valid    <= pop;
            out_mcu_last <= pop && (bypass ? tag_last : tag_mem[rd_ptr][0]);
            if (pop) out_comp <= bypass ? cand : tag_mem[rd_ptr][2:1];

            if ((credit_return && (credits_avail == CRED_MAX)) || (q_out_enable && !pop))
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue && !bypass) tag_mem[wr_ptr] <= {cand, tag_last};
    end

endmodule

// File: tb/tb_quant_scheduler.sv
// Bench for quant_scheduler: a strict-MCU and a round-robin instance, each with a
// fixed-latency quantizer stub and an optional auto-returning downstream stub.
module tb_quant_scheduler;

    localparam int CREDITS = 8;
    localparam int CW      = $clog2(CREDITS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req = 3'b000;
    logic          auto_ret = 1'b0;
    logic          man_ret = 1'b0;
    logic          inj = 1'b0;

    logic [2:0]    gnt_s, gnt_r;
    logic [1:0]    q_sel_s, q_sel_r;
    logic          q_enable_s, q_enable_r;
    logic          q_out_enable_s, q_out_enable_r;
    logic          out_valid_s, out_valid_r;
    logic [1:0]    out_comp_s, out_comp_r;
    logic          out_mcu_last_s, out_mcu_last_r;
    logic          credit_return_s, credit_return_r;
    logic [CW-1:0] credits_s, credits_r;
    logic          busy_s, busy_r;
    logic          err_s, err_r;
    logic [3:0]    sr_s, sr_r;

    always #5 clk = ~clk;

    quant_scheduler #(.STRICT_MCU(1), .Y_PER_MCU(4), .Q_LAT(4), .CREDITS(CREDITS)) dut_s (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_s), .q_sel(q_sel_s), .q_enable(q_enable_s),
        .q_out_enable(q_out_enable_s), .out_valid(out_valid_s), .out_comp(out_comp_s),
        .out_mcu_last(out_mcu_last_s), .credit_return(credit_return_s),
        .credits_avail(credits_s), .busy(busy_s), .err(err_s)
    );

    quant_scheduler #(.STRICT_MCU(0), .Y_PER_MCU(4), .Q_LAT(4), .CREDITS(CREDITS)) dut_r (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_r), .q_sel(q_sel_r), .q_enable(q_enable_r),
        .q_out_enable(q_out_enable_r), .out_valid(out_valid_r), .out_comp(out_comp_r),
        .out_mcu_last(out_mcu_last_r), .credit_return(credit_return_r),
        .credits_avail(credits_r), .busy(busy_r), .err(err_r)
    );

    // quantizer stubs: 4-cycle enable-to-result delay, reset together with the scheduler
    always @(posedge clk) begin
        if (rst) begin
            sr_s <= '0;
            sr_r <= '0;
        end else begin
            sr_s <= {sr_s[2:0], q_enable_s};
            sr_r <= {sr_r[2:0], q_enable_r};
        end
    end
    assign q_out_enable_s  = sr_s[3] | inj;
    assign q_out_enable_r  = sr_r[3] | inj;
    assign credit_return_s = man_ret | (auto_ret & out_valid_s);
    assign credit_return_r = man_ret | (auto_ret & out_valid_r);

    typedef struct {
        logic       rr;
        logic       rst_first;
        logic [2:0] req;
        logic [2:0] exp_gnt;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        man_ret = 1'b0;
        inj = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, "_gnt"}, gnt_s, 0);
        chk({tag, "_q_sel"}, q_sel_s, 0);
        chk({tag, "_q_enable"}, q_enable_s, 0);
        chk({tag, "_out_valid"}, out_valid_s, 0);
        chk({tag, "_out_comp"}, out_comp_s, 0);
        chk({tag, "_mcu_last"}, out_mcu_last_s, 0);
        chk({tag, "_credits"}, credits_s, CREDITS);
        chk({tag, "_busy"}, busy_s, 0);
        chk({tag, "_err"}, err_s, 0);
    endtask

    function automatic logic [1:0] oh2i(input logic [2:0] g);
        return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
    endfunction

    function automatic void add(input logic rr, input logic rf, input logic [2:0] r,
                                input logic [2:0] g);
        vec_t v;
        v.rr = rr;
        v.rst_first = rf;
        v.req = r;
        v.exp_gnt = g;
        vt.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] hist [0:31];
        logic [2:0] e;
        logic [2:0] t5_seq [0:7];
        int cyc;
        int ngr;

        // strict MCU order with all requesters held: Y,Y,Y,Y,Cb,Cr repeating
        for (int m = 0; m < 3; m++)
            for (int k = 0; k < 6; k++)
                add(1'b0, (m == 0 && k == 0), 3'b111,
                    (k < 4) ? 3'b001 : ((k == 4) ? 3'b010 : 3'b100));
        // round robin: Y/Cr alternate, then Cb joins without starvation
        add(1'b1, 1'b1, 3'b101, 3'b001);
        add(1'b1, 1'b0, 3'b101, 3'b100);
        add(1'b1, 1'b0, 3'b101, 3'b001);
        add(1'b1, 1'b0, 3'b101, 3'b100);
        add(1'b1, 1'b0, 3'b111, 3'b001);
        add(1'b1, 1'b0, 3'b111, 3'b010);
        add(1'b1, 1'b0, 3'b111, 3'b100);
        add(1'b1, 1'b0, 3'b111, 3'b001);
        add(1'b1, 1'b0, 3'b111, 3'b010);
        add(1'b1, 1'b0, 3'b111, 3'b100);
        add(1'b1, 1'b0, 3'b110, 3'b010);
        add(1'b1, 1'b0, 3'b100, 3'b100);
        add(1'b1, 1'b0, 3'b011, 3'b001);

        do_reset();
        chk_reset_s("rst");
        chk("rst_r_credits", credits_r, CREDITS);
        chk("rst_r_gnt", gnt_r, 0);

        cyc = 0;
        for (int i = 0; i < 32; i++) hist[i] = 3'b000;
        foreach (vt[i]) begin
            if (vt[i].rst_first) begin
                do_reset();
                auto_ret = 1'b1;
                cyc = 0;
                for (int j = 0; j < 32; j++) hist[j] = 3'b000;
            end
            req = vt[i].req;
            tick();
            cyc++;
            if (!vt[i].rr) begin
                chk("t1_gnt", gnt_s, vt[i].exp_gnt);
                chk("t1_q_enable", q_enable_s, vt[i].exp_gnt != 3'b000);
                chk("t1_q_sel", q_sel_s, oh2i(vt[i].exp_gnt));
                hist[cyc] = vt[i].exp_gnt;
                e = (cyc >= 5) ? hist[cyc-5] : 3'b000;
                chk("t1_out_valid", out_valid_s, e != 3'b000);
                if (e != 3'b000) begin
                    chk("t1_out_comp", out_comp_s, oh2i(e));
                    chk("t1_mcu_last", out_mcu_last_s, e == 3'b100);
                end
                if (cyc == 18) chk("t1_credits_steady", credits_s, 2);
            end else begin
                chk("t3_gnt", gnt_r, vt[i].exp_gnt);
                chk("t3_q_sel", q_sel_r, oh2i(vt[i].exp_gnt));
                chk("t3_mcu_last", out_mcu_last_r, 0);
            end
        end

        // T2: credits run dry after 8 grants; one return buys exactly one more
        do_reset();
        auto_ret = 1'b0;
        req = 3'b111;
        ngr = 0;
        repeat (12) begin
            tick();
            if (gnt_s != 3'b000) ngr++;
        end
        chk("t2_grants", ngr, 8);
        chk("t2_credits_zero", credits_s, 0);
        chk("t2_gnt_idle", gnt_s, 0);
        chk("t2_q_enable_idle", q_enable_s, 0);
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        ngr = 0;
        repeat (8) begin
            tick();
            if (gnt_s != 3'b000) ngr++;
        end
        chk("t2_extra_grants", ngr, 1);
        chk("t2_credits_after", credits_s, 0);

        // T4: issue and return together at 3 credits, then overflow return
        do_reset();
        auto_ret = 1'b0;
        req = 3'b111;
        repeat (5) tick();
        chk("t4_credits_3", credits_s, 3);
        man_ret = 1'b1;
        tick();
        chk("t4_simul_credits", credits_s, 3);
        chk("t4_simul_gnt", gnt_s, 3'b100);
        req = 3'b000;
        repeat (5) tick();
        chk("t4_credits_full", credits_s, CREDITS);
        chk("t4_err_clear", err_s, 0);
        tick();
        man_ret = 1'b0;
        chk("t4_overflow_credits", credits_s, CREDITS);
        chk("t4_err_set", err_s, 1);
        repeat (3) tick();
        chk("t4_err_sticky", err_s, 1);

        // T5: 8 back-to-back issues, results come back in grant order
        t5_seq[0] = 3'b001; t5_seq[1] = 3'b001; t5_seq[2] = 3'b001; t5_seq[3] = 3'b001;
        t5_seq[4] = 3'b010; t5_seq[5] = 3'b100; t5_seq[6] = 3'b001; t5_seq[7] = 3'b001;
        do_reset();
        auto_ret = 1'b1;
        req = 3'b111;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c <= 8) chk("t5_gnt", gnt_s, t5_seq[c-1]);
            if (c == 8) req = 3'b000;
            chk("t5_busy", busy_s, c <= 12);
            chk("t5_out_valid", out_valid_s, (c >= 6) && (c <= 13));
            if (c >= 6 && c <= 13) begin
                chk("t5_out_comp", out_comp_s, oh2i(t5_seq[c-6]));
                chk("t5_mcu_last", out_mcu_last_s, t5_seq[c-6] == 3'b100);
            end
        end
        chk("t5_err", err_s, 0);
        chk("t5_credits", credits_s, CREDITS);

        // T6: reset with a block in flight, then an orphan quantizer result
        do_reset();
        auto_ret = 1'b0;
        req = 3'b001;
        tick();
        chk("t6_gnt", gnt_s, 3'b001);
        req = 3'b000;
        tick();
        tick();
        chk("t6_busy_before", busy_s, 1);
        chk("t6_credits_before", credits_s, CREDITS - 1);
        rst = 1'b1;
        tick();
        chk_reset_s("t6_rst");
        rst = 1'b0;
        repeat (4) tick();
        chk("t6_no_stale_valid", out_valid_s, 0);
        chk("t6_no_stale_err", err_s, 0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("t6_orphan_err", err_s, 1);
        chk("t6_orphan_valid", out_valid_s, 0);
        tick();
        chk("t6_err_sticky", err_s, 1);
        chk("t6_valid_stays_0", out_valid_s, 0);

        // push and pop on an empty FIFO in the same cycle: tag passes straight through
        do_reset();
        req = 3'b100;
        inj = 1'b1;
        tick();
        req = 3'b000;
        inj = 1'b0;
        chk("byp_gnt", gnt_r, 3'b100);
        chk("byp_out_valid", out_valid_r, 1);
        chk("byp_out_comp", out_comp_r, 2);
        chk("byp_busy", busy_r, 0);
        chk("byp_err", err_r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
